gfau_seq: RTL

//  Initiator-side controller for the GF(p) arithmetic unit. Runs a host-loaded

---
 rtl/gfau_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/gfau_seq.sv
// Program sequencer for the GF(p) arithmetic unit: issues buffered instructions
// over a 4-entry register file, waits for each result and writes it back.
module gfau_seq #(
    parameter int unsigned SIZE    = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       reg_we,
    input  logic [1:0]                 reg_addr,
    input  logic [SIZE-1:0]            reg_wdata,
    input  logic [1:0]                 reg_raddr,
    output logic [SIZE-1:0]            reg_rdata,
    input  logic                       instr_we,
    input  logic [$clog2(DEPTH)-1:0]   instr_addr,
    input  logic [7:0]                 instr_wdata,
    input  logic [$clog2(DEPTH):0]     prog_len,
    input  logic [SIZE-1:0]            prime_in,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [SIZE-1:0]            in_0,
    output logic [SIZE-1:0]            in_1,
    output logic [SIZE-1:0]            prime,
    output logic [1:0]                 operation_select,
    output logic                       GFAU_done_from_control,
    input  logic [SIZE-1:0]            result,
    input  logic                       GFAU_done_to_control
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB, S_FIN} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     pc_q, pc_d, issue_pc;
    logic [LW-1:0]     len_q, len_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SIZE-1:0]   res_q, res_d;
    logic [SIZE-1:0]   rf_q [4];
    logic [SIZE-1:0]   rf_d [4];
    logic [7:0]        ib_q [DEPTH];
    logic [7:0]        ib_d [DEPTH];
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d, stb_q, stb_d;
    logic [SIZE-1:0]   in0_q, in0_d, in1_q, in1_d, prime_q, prime_d;
    logic [1:0]        op_q, op_d;
    logic              issue;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        rf_d     = rf_q;
        ib_d     = ib_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        stb_d    = 1'b0;
        in0_d    = in0_q;
        in1_d    = in1_q;
        prime_d  = prime_q;
        op_d     = op_q;
        issue    = 1'b0;
        issue_pc = pc_q;

        case (state_q)
            S_IDLE: begin
                if (reg_we)   rf_d[reg_addr]   = reg_wdata;
                if (instr_we) ib_d[instr_addr] = instr_wdata;
                if (start) begin
                    prime_d = prime_in;
                    len_d   = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
                    pc_d    = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    if (len_d == '0) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = S_ISSUE;
                        issue    = 1'b1;
                        issue_pc = '0;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (GFAU_done_to_control) begin
                    res_d   = result;
                    state_d = S_WB;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WB: begin
                rf_d[ib_q[pc_q][5:4]] = res_q;
                pc_d = pc_q + PW'(1);
                if (({1'b0, pc_q} + LW'(1)) == len_q) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d  = S_ISSUE;
                    issue    = 1'b1;
                    issue_pc = pc_q + PW'(1);
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Operands read from the post-write-back file so dst==src chains forward.
        if (issue) begin
            stb_d = 1'b1;
            op_d  = ib_d[issue_pc][7:6];
            in0_d = rf_d[ib_d[issue_pc][3:2]];
            in1_d = rf_d[ib_d[issue_pc][1:0]];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            stb_q   <= 1'b0;
            in0_q   <= '0;
            in1_q   <= '0;
            prime_q <= '0;
            op_q    <= '0;
            for (int unsigned i = 0; i < 4; i++)     rf_q[i] <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) ib_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            stb_q   <= stb_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            prime_q <= prime_d;
            op_q    <= op_d;
            rf_q    <= rf_d;
            ib_q    <= ib_d;
        end
    end

    assign reg_rdata              = rf_q[reg_raddr];
    assign busy                   = busy_q;
    assign done                   = done_q;
    assign error                  = err_q;
    assign in_0                   = in0_q;
    assign in_1                   = in1_q;
    assign prime                  = prime_q;
    assign operation_select       = op_q;
    assign GFAU_done_from_control = stb_q;

endmodule
